// File: rtl/bp_me_burst_mux_pkg.sv
// Shared types and constants for the BedRock burst round-robin mux.
//   state_e            : mux FSM states (e_idle, e_data)
//   msg_count_width_gp : width of each per-source completed-message counter
package bp_me_burst_mux_pkg;

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_data = 1'b1
    } state_e;

    localparam int unsigned msg_count_width_gp = 16;

endpackage

// File: rtl/bp_me_burst_rr_arb.sv
// Round-robin picker with its pointer register.
// Picks the lowest index at or after rr_ptr whose request is set, wrapping
// modulo num_src_p. The pointer moves to winner+1 when advance_i is high.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i              : per-source request vector
//   advance_i        : grant accepted this cycle; move pointer past winner
//   winner_o         : selected source index (0 when nothing requests)
//   found_o          : at least one request present
module bp_me_burst_rr_arb #(
    parameter int num_src_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_src_p-1:0]         v_i,
    input  logic                         advance_i,
    output logic [$clog2(num_src_p)-1:0] winner_o,
    output logic                         found_o
);

    localparam int id_w_lp = $clog2(num_src_p);

    logic [id_w_lp-1:0] rr_ptr_q;
    logic [id_w_lp-1:0] idx;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < num_src_p; i++) begin
            idx = id_w_lp'((32'(rr_ptr_q) + i) % num_src_p);
            if (!found_o && v_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_q <= '0;
        end else if (advance_i) begin
            rr_ptr_q <= (winner_o == id_w_lp'(num_src_p - 1)) ? '0 : winner_o + 1'b1;
        end
    end

endmodule

// File: rtl/bp_me_burst_rr_mux.sv
// N-to-1 BedRock burst mux. Headers are arbitrated round-robin; the grant is
// then locked to the winning source until its last data beat transfers, so
// beats of different messages never interleave. All outputs are combinational
// passthroughs of the selected source (zero added latency).
// Optional feature macro: BP_ME_BURST_MUX_STATS_EN enables per-source 16-bit
// completed-message counters on msg_count_o (tied to 0 otherwise).
// Ports:
//   clk_i, reset_n_i                     : clock, asynchronous active-low reset
//   src_header_*                         : per-source header channel (in)
//   src_data_*                           : per-source data channel (in)
//   header_o/header_v_o/header_ready_and_i : merged header channel
//   data_o/data_v_o/data_last_o/data_ready_and_i : merged data channel
//   grant_id_o                           : selected (idle) or locked (data) source
//   overrun_o                            : sticky, a message exceeded max_beats_p
//   msg_count_o                          : per-source message counters
module bp_me_burst_rr_mux
    import bp_me_burst_mux_pkg::*;
#(
    parameter int num_src_p      = 4,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int max_beats_p    = 8
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [num_src_p*header_width_p-1:0]        src_header_i,
    input  logic [num_src_p-1:0]                       src_header_has_data_i,
    input  logic [num_src_p-1:0]                       src_header_v_i,
    output logic [num_src_p-1:0]                       src_header_ready_and_o,
    input  logic [num_src_p*data_width_p-1:0]          src_data_i,
    input  logic [num_src_p-1:0]                       src_data_v_i,
    input  logic [num_src_p-1:0]                       src_data_last_i,
    output logic [num_src_p-1:0]                       src_data_ready_and_o,
    output logic [header_width_p-1:0]                  header_o,
    output logic                                       header_v_o,
    input  logic                                       header_ready_and_i,
    output logic [data_width_p-1:0]                    data_o,
    output logic                                       data_v_o,
    output logic                                       data_last_o,
    input  logic                                       data_ready_and_i,
    output logic [$clog2(num_src_p)-1:0]               grant_id_o,
    output logic                                       overrun_o,
    output logic [msg_count_width_gp*num_src_p-1:0]    msg_count_o
);

    localparam int id_w_lp  = $clog2(num_src_p);
    localparam int cnt_w_lp = $clog2(max_beats_p + 1);

    state_e              state_q;
    logic [id_w_lp-1:0]  lock_id_q;
    logic [cnt_w_lp-1:0] beat_cnt_q;
    logic [id_w_lp-1:0]  winner;
    logic                found;
    logic [num_src_p-1:0] arb_v;
    logic                header_hs;
    logic                data_hs;

    // Requests are masked outside e_idle so a locked burst cannot be pre-empted.
    always_comb begin
        arb_v = (state_q == e_idle) ? src_header_v_i : '0;
    end

    bp_me_burst_rr_arb #(
        .num_src_p(num_src_p)
    ) arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (arb_v),
        .advance_i (header_hs),
        .winner_o  (winner),
        .found_o   (found)
    );

    // Output steering; everything is forced to 0 while reset is asserted.
    always_comb begin
        header_o               = '0;
        header_v_o             = 1'b0;
        src_header_ready_and_o = '0;
        data_o                 = '0;
        data_v_o               = 1'b0;
        data_last_o            = 1'b0;
        src_data_ready_and_o   = '0;
        grant_id_o             = '0;
        if (reset_n_i) begin
            if (state_q == e_idle) begin
                grant_id_o                     = winner;
                header_o                       = src_header_i[winner*header_width_p +: header_width_p];
                header_v_o                     = found;
                src_header_ready_and_o[winner] = found & header_ready_and_i;
            end else begin
                grant_id_o                      = lock_id_q;
                data_o                          = src_data_i[lock_id_q*data_width_p +: data_width_p];
                data_v_o                        = src_data_v_i[lock_id_q];
                data_last_o                     = src_data_last_i[lock_id_q];
                src_data_ready_and_o[lock_id_q] = data_ready_and_i;
            end
        end
    end

    always_comb begin
        header_hs = header_v_o & header_ready_and_i;
        data_hs   = data_v_o & data_ready_and_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
            overrun_o  <= 1'b0;
        end else begin
            case (state_q)
                e_idle: begin
                    if (header_hs && src_header_has_data_i[winner]) begin
                        lock_id_q  <= winner;
                        beat_cnt_q <= '0;
                        state_q    <= e_data;
                    end
                end
                e_data: begin
                    if (data_hs) begin
                        if (beat_cnt_q != cnt_w_lp'(max_beats_p)) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                        if (data_last_o) begin
                            state_q <= e_idle;
                        end else if (beat_cnt_q == cnt_w_lp'(max_beats_p - 1)) begin
                            overrun_o <= 1'b1;
                        end
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

`ifdef BP_ME_BURST_MUX_STATS_EN
    logic [msg_count_width_gp-1:0] msg_count_q [num_src_p];

    // A message completes either on a header-only handshake or on its last beat;
    // the two handshakes are mutually exclusive by state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < num_src_p; i++) begin
                msg_count_q[i] <= '0;
            end
        end else if (header_hs && !src_header_has_data_i[winner]) begin
            msg_count_q[winner] <= msg_count_q[winner] + 1'b1;
        end else if (data_hs && data_last_o) begin
            msg_count_q[lock_id_q] <= msg_count_q[lock_id_q] + 1'b1;
        end
    end

    always_comb begin
        msg_count_o = '0;
        for (int unsigned i = 0; i < num_src_p; i++) begin
            msg_count_o[i*msg_count_width_gp +: msg_count_width_gp] = msg_count_q[i];
        end
    end
`else
    always_comb begin
        msg_count_o = '0;
    end
`endif

endmodule

// File: tb/tb_bp_me_burst_rr_mux.sv
module tb_bp_me_burst_rr_mux;

    localparam int TMO = 100;

    typedef struct {
        bit          is_data;
        logic [1:0]  id;
        logic [63:0] val;
        bit          last;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] src_header_i;
    logic [3:0]   hhd = '0;
    logic [3:0]   hv = '0;
    logic [3:0]   src_header_ready_and_o;
    logic [255:0] src_data_i;
    logic [3:0]   dv = '0;
    logic [3:0]   dl = '0;
    logic [3:0]   src_data_ready_and_o;
    logic [63:0]  header_o;
    logic         header_v_o;
    logic         hrdy = 1'b1;
    logic [63:0]  data_o;
    logic         data_v_o;
    logic         data_last_o;
    logic         drdy = 1'b1;
    logic [1:0]   grant_id_o;
    logic         overrun_o;
    logic [63:0]  msg_count_o;

    logic [63:0]  hd [4];
    logic [63:0]  dd [4];
    bit           abort = 1'b0;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    logic mon_hh, mon_dh;
    ev_t  mon_e;

    bp_me_burst_rr_mux #(
        .num_src_p(4),
        .header_width_p(64),
        .data_width_p(64),
        .max_beats_p(8)
    ) dut (
        .clk_i                 (clk),
        .reset_n_i             (rst_n),
        .src_header_i          (src_header_i),
        .src_header_has_data_i (hhd),
        .src_header_v_i        (hv),
        .src_header_ready_and_o(src_header_ready_and_o),
        .src_data_i            (src_data_i),
        .src_data_v_i          (dv),
        .src_data_last_i       (dl),
        .src_data_ready_and_o  (src_data_ready_and_o),
        .header_o              (header_o),
        .header_v_o            (header_v_o),
        .header_ready_and_i    (hrdy),
        .data_o                (data_o),
        .data_v_o              (data_v_o),
        .data_last_o           (data_last_o),
        .data_ready_and_i      (drdy),
        .grant_id_o            (grant_id_o),
        .overrun_o             (overrun_o),
        .msg_count_o           (msg_count_o)
    );

    initial forever #5 clk = ~clk;

    always_comb begin
        src_header_i = '0;
        src_data_i   = '0;
        for (int i = 0; i < 4; i++) begin
            src_header_i[i*64 +: 64] = hd[i];
            src_data_i[i*64 +: 64]   = dd[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_tmo(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    function automatic void push_hdr(input int id, input logic [63:0] val);
        ev_t e;
        e.is_data = 1'b0; e.id = 2'(id); e.val = val; e.last = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_beat(input int id, input logic [63:0] val, input bit last);
        ev_t e;
        e.is_data = 1'b1; e.id = 2'(id); e.val = val; e.last = last;
        exp_q.push_back(e);
    endfunction

    // Source-side driver: header (data beat 0 presented alongside it), then beats.
    task automatic send_msg(input int s, input logic [63:0] hdr, input bit has_data,
                            input int nbeats, input logic [63:0] base, input bit last_en);
        int t;
        hd[s] = hdr; hhd[s] = has_data; hv[s] = 1'b1;
        if (has_data && nbeats > 0) begin
            dd[s] = base; dl[s] = last_en && (nbeats == 1); dv[s] = 1'b1;
        end
        t = 0;
        @(negedge clk);
        while (!src_header_ready_and_o[s] && !abort && t < TMO) begin
            @(negedge clk); t++;
        end
        if (abort || t >= TMO) begin
            if (!abort) fail_tmo("src_hdr_wait");
            hv[s] = 1'b0; dv[s] = 1'b0; dl[s] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        hv[s] = 1'b0;
        if (has_data) begin
            for (int b = 0; b < nbeats; b++) begin
                dd[s] = base + 64'(b); dl[s] = last_en && (b == nbeats - 1); dv[s] = 1'b1;
                t = 0;
                @(negedge clk);
                while (!src_data_ready_and_o[s] && !abort && t < TMO) begin
                    @(negedge clk); t++;
                end
                if (abort || t >= TMO) begin
                    if (!abort) fail_tmo("src_data_wait");
                    dv[s] = 1'b0; dl[s] = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
        end
        dv[s] = 1'b0; dl[s] = 1'b0;
    endtask

    task automatic wait_hdr_of(input int s);
        int t = 0;
        @(negedge clk);
        while (!(header_v_o && hrdy && grant_id_o == 2'(s)) && t < TMO) begin
            @(negedge clk); t++;
        end
        if (t >= TMO) fail_tmo("wait_grant");
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            mon_hh = header_v_o && hrdy;
            mon_dh = data_v_o && drdy;
            if (mon_hh && mon_dh) begin
                n_checks++; n_fail++;
                $display("FAIL hdr_data_same_cycle actual=both required=one");
            end else if (mon_hh || mon_dh) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_xfer actual data=%0d id=%0d val=%0h required=none",
                             mon_dh, grant_id_o, mon_hh ? header_o : data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_hh && (mon_e.is_data || header_o !== mon_e.val || grant_id_o !== mon_e.id)) begin
                        n_fail++;
                        $display("FAIL hdr_xfer actual hdr id=%0d val=%0h required data=%0d id=%0d val=%0h",
                                 grant_id_o, header_o, mon_e.is_data, mon_e.id, mon_e.val);
                    end else if (mon_dh && (!mon_e.is_data || data_o !== mon_e.val ||
                                 data_last_o !== mon_e.last || grant_id_o !== mon_e.id)) begin
                        n_fail++;
                        $display("FAIL data_xfer actual beat id=%0d val=%0h last=%0d required data=%0d id=%0d val=%0h last=%0d",
                                 grant_id_o, data_o, data_last_o, mon_e.is_data, mon_e.id, mon_e.val, mon_e.last);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin hd[i] = '0; dd[i] = '0; end
        // Reset with a pending request: outputs must stay quiet.
        hd[2] = 64'hDEAD; hv[2] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_header_v", 64'(header_v_o), 0);
        check("rst_hdr_ready", 64'(src_header_ready_and_o), 0);
        check("rst_data_v", 64'(data_v_o), 0);
        check("rst_grant", 64'(grant_id_o), 0);
        check("rst_overrun", 64'(overrun_o), 0);
        check("rst_msg_count", msg_count_o, 0);
        @(posedge clk); #1;
        hv[2] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single header-only message from src2 (rr_ptr 0 -> 3).
        push_hdr(2, 64'h2001);
        send_msg(2, 64'h2001, 1'b0, 0, 0, 1'b0);

        // Fairness: all valid, pointer at 3 -> 3,0,1,2,3,0,1,2.
        for (int r = 0; r < 2; r++) begin
            push_hdr(3, 64'h330 + 64'(r)); push_hdr(0, 64'h300 + 64'(r));
            push_hdr(1, 64'h310 + 64'(r)); push_hdr(2, 64'h320 + 64'(r));
        end
        fork
            begin send_msg(0, 64'h300, 0, 0, 0, 0); send_msg(0, 64'h301, 0, 0, 0, 0); end
            begin send_msg(1, 64'h310, 0, 0, 0, 0); send_msg(1, 64'h311, 0, 0, 0, 0); end
            begin send_msg(2, 64'h320, 0, 0, 0, 0); send_msg(2, 64'h321, 0, 0, 0, 0); end
            begin send_msg(3, 64'h330, 0, 0, 0, 0); send_msg(3, 64'h331, 0, 0, 0, 0); end
        join
        @(posedge clk); #1;

        // Burst locking: src0 4 beats while src1 header waits (pointer at 3).
        push_hdr(0, 64'h400);
        for (int b = 0; b < 4; b++) push_beat(0, 64'hA0 + 64'(b), b == 3);
        push_hdr(1, 64'h410);
        fork
            send_msg(0, 64'h400, 1'b1, 4, 64'hA0, 1'b1);
            send_msg(1, 64'h410, 1'b0, 0, 0, 1'b0);
        join
        @(posedge clk); #1;

        // Backpressure: src3 3 beats, sink ready 1,0,1,0,1 (pointer at 2).
        push_hdr(3, 64'h530);
        for (int b = 0; b < 3; b++) push_beat(3, 64'hD0 + 64'(b), b == 2);
        drdy = 1'b0;
        fork
            send_msg(3, 64'h530, 1'b1, 3, 64'hD0, 1'b1);
            begin
                logic [4:0] pat;
                pat = 5'b10101;
                wait_hdr_of(3);
                @(posedge clk); #1;
                for (int k = 0; k < 5; k++) begin
                    drdy = pat[4-k];
                    @(negedge clk);
                    check("bp_ready_mirror", 64'(src_data_ready_and_o), {60'b0, drdy, 3'b0});
                    @(posedge clk); #1;
                end
                check("bp_3_in_5", 64'(exp_q.size()), 0);
                drdy = 1'b1;
            end
        join
        @(posedge clk); #1;

        // Overrun: src1 sends 9 beats with no last (pointer at 0).
        push_hdr(1, 64'h610);
        for (int b = 0; b < 9; b++) push_beat(1, 64'hB0 + 64'(b), 1'b0);
        fork
            send_msg(1, 64'h610, 1'b1, 9, 64'hB0, 1'b0);
            begin
                wait_hdr_of(1);
                @(posedge clk);
                repeat (7) @(posedge clk);
                #2 check("overrun_after_7", 64'(overrun_o), 0);
                @(posedge clk);
                #2 check("overrun_after_8", 64'(overrun_o), 1);
            end
        join
        repeat (2) @(posedge clk);
        #1 check("overrun_sticky", 64'(overrun_o), 1);

        // Reset to recover, then reset mid-burst.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("overrun_cleared", 64'(overrun_o), 0);
        push_hdr(0, 64'h700);
        push_beat(0, 64'hC0, 1'b0);
        push_beat(0, 64'hC1, 1'b0);
        fork
            send_msg(0, 64'h700, 1'b1, 4, 64'hC0, 1'b1);
            begin
                wait_hdr_of(0);
                @(posedge clk);
                @(posedge clk);
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                check("mid_rst_header_v", 64'(header_v_o), 0);
                check("mid_rst_data_v", 64'(data_v_o), 0);
                check("mid_rst_data", data_o, 0);
                check("mid_rst_last", 64'(data_last_o), 0);
                check("mid_rst_grant", 64'(grant_id_o), 0);
                check("mid_rst_data_ready", 64'(src_data_ready_and_o), 0);
            end
        join
        @(posedge clk); #1;
        rst_n = 1'b1;
        abort = 1'b0;
        check("post_rst_msg_count", msg_count_o, 0);
        check("post_rst_scoreboard", 64'(exp_q.size()), 0);
        // rr_ptr back at 0: src0 must beat src3.
        push_hdr(0, 64'h800);
        push_hdr(3, 64'h830);
        fork
            send_msg(0, 64'h800, 0, 0, 0, 0);
            send_msg(3, 64'h830, 0, 0, 0, 0);
        join
        repeat (2) @(posedge clk);
        #1 check("final_scoreboard_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
